mem_arbiter: RTL and testbench

//  Shares the single memory port between two bus masters: M0 (core) and M1 (DMA/debug).

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/mem_arbiter_if.sv | 20 ++
 rtl/arb_rr_pick.sv | 14 +
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
    typedef logic master_id_t;
    localparam logic [2:0]  MEM_MODE_WORD = 3'b111;
    localparam logic [31:0] ARB_ERR_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: per-master request/response bus plus the downstream memory port.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic [1:0]            m_req, m_wen, m_ack, m_err;
    logic [1:0][2:0]       m_mode;
    logic [1:0][XLEN-1:0]  m_addr, m_wdata, m_rdata;
    logic                  mem_req, mem_wen, mem_ready, grant_id;
    logic [2:0]            mem_mode;
    logic [XLEN-1:0]       mem_addr, mem_dat_o, mem_dat_i;

    modport slave (
        input  m_req, m_wen, m_mode, m_addr, m_wdata, mem_dat_i, mem_ready,
        output m_rdata, m_ack, m_err, mem_req, mem_wen, mem_mode, mem_addr, mem_dat_o, grant_id
    );
    modport master (
        output m_req, m_wen, m_mode, m_addr, m_wdata, mem_dat_i, mem_ready,
        input  m_rdata, m_ack, m_err, mem_req, mem_wen, mem_mode, mem_addr, mem_dat_o, grant_id
    );
endinterface

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: two-way round-robin pick; a tie goes to the master that did not win last.
module arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_grant,
    output logic       valid,
    output master_id_t winner
);
    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last_grant : req[1];
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between two masters, one access in flight.
// Define MEM_ARB_TIMEOUT_EN to abort an access stuck in BUSY for TIMEOUT cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    arb_state_t state;
    master_id_t last_grant, winner;
    logic       pick_valid;

    arb_rr_pick u_pick (
        .req        (bus.m_req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .winner     (winner)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timed_out;
    assign timed_out = wait_cnt == 8'(TIMEOUT);
`else
    logic unused_cfg;
    assign unused_cfg = ^{8'(TIMEOUT), ARB_ERR_RDATA};
    assign bus.m_err  = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            bus.mem_req   <= 1'b0;
            bus.mem_wen   <= 1'b0;
            bus.mem_mode  <= '0;
            bus.mem_addr  <= '0;
            bus.mem_dat_o <= '0;
            bus.grant_id  <= 1'b0;
            bus.m_rdata   <= '0;
            bus.m_ack     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            bus.m_err     <= '0;
            wait_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (pick_valid) begin
                    bus.mem_req   <= 1'b1;
                    bus.mem_wen   <= bus.m_wen[winner];
                    bus.mem_mode  <= bus.m_mode[winner];
                    bus.mem_addr  <= bus.m_addr[winner];
                    bus.mem_dat_o <= bus.m_wdata[winner];
                    bus.grant_id  <= winner;
`ifdef MEM_ARB_TIMEOUT_EN
                    wait_cnt      <= '0;
`endif
                    state         <= BUSY;
                end
                BUSY: if (bus.mem_ready) begin
                    bus.m_rdata[bus.grant_id] <= bus.mem_dat_i;
                    bus.m_ack[bus.grant_id]   <= 1'b1;
                    bus.mem_req               <= 1'b0;
                    bus.mem_wen               <= 1'b0;
                    last_grant                <= bus.grant_id;
                    state                     <= RESP;
`ifdef MEM_ARB_TIMEOUT_EN
                end else if (timed_out) begin
                    bus.m_rdata[bus.grant_id] <= XLEN'(ARB_ERR_RDATA);
                    bus.m_ack[bus.grant_id]   <= 1'b1;
                    bus.m_err[bus.grant_id]   <= 1'b1;
                    bus.mem_req               <= 1'b0;
                    last_grant                <= bus.grant_id;
                    state                     <= RESP;
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
`endif
                end
                RESP: begin
                    bus.m_ack <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    bus.m_err <= '0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level reference model checked every cycle.
module tb_mem_arbiter;
    import mem_arb_pkg::*;
    localparam int XLEN = 32;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.XLEN(XLEN)) bus();
    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: who owns the port, and what each output must show.
    int               owner, busy_n;
    bit               resp, mdl_last;
    logic [1:0]       e_ack, e_err;
    logic [1:0][31:0] e_rdata;
    logic             e_req, e_wen, e_gid;
    logic [2:0]       e_mode;
    logic [31:0]      e_addr, e_dato;

    task automatic complete(input int g, input logic [31:0] d, input bit err);
        e_rdata[g] = d;
        e_ack[g]   = 1'b1;
        e_err[g]   = err;
        e_req      = 1'b0;
        if (!err) e_wen = 1'b0;
        mdl_last   = g[0];
        owner      = -1;
        resp       = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst) begin
            owner = -1; busy_n = 0; resp = 0; mdl_last = 1;
            e_ack = '0; e_err = '0; e_rdata = '0; e_req = 0; e_wen = 0; e_gid = 0;
            e_mode = '0; e_addr = '0; e_dato = '0;
        end else begin
            e_ack = '0;
            e_err = '0;
            if (resp) resp = 0;
            else if (owner < 0) begin
                if (bus.m_req != 2'b00) begin
                    owner  = (bus.m_req == 2'b11) ? int'(!mdl_last) : int'(bus.m_req[1]);
                    e_req  = 1'b1;
                    e_wen  = bus.m_wen[owner];
                    e_mode = bus.m_mode[owner];
                    e_addr = bus.m_addr[owner];
                    e_dato = bus.m_wdata[owner];
                    e_gid  = owner[0];
                    busy_n = 0;
                end
            end else if (bus.mem_ready) complete(owner, bus.mem_dat_i, 1'b0);
`ifdef MEM_ARB_TIMEOUT_EN
            else if (busy_n == TMO) complete(owner, ARB_ERR_RDATA, 1'b1);
            else busy_n++;
`endif
        end
    end

    initial forever begin
        @(negedge clk);
        chk("m_ack", bus.m_ack, e_ack);
        chk("m_err", bus.m_err, e_err);
        chk("m_rdata", bus.m_rdata, e_rdata);
        chk("mem_req", bus.mem_req, e_req);
        chk("mem_wen", bus.mem_wen, e_wen);
        chk("mem_mode", bus.mem_mode, e_mode);
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_dat_o", bus.mem_dat_o, e_dato);
        chk("grant_id", bus.grant_id, e_gid);
    end

    // Masters drop their request once they have seen their ack.
    task automatic tick();
        logic [1:0] a;
        @(posedge clk);
        a = bus.m_ack;
        #1;
        bus.m_req = bus.m_req & ~a;
    endtask

    task automatic set_req(input int m, input logic wen, input logic [2:0] mode,
                           input logic [31:0] addr, input logic [31:0] wdata);
        bus.m_wen[m]   = wen;
        bus.m_mode[m]  = mode;
        bus.m_addr[m]  = addr;
        bus.m_wdata[m] = wdata;
        bus.m_req[m]   = 1'b1;
    endtask

    initial begin
        bus.m_req = '0; bus.m_wen = '0; bus.m_mode = '0; bus.m_addr = '0; bus.m_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_dat_i = '0;
        repeat (3) tick();
        rst = 1'b1;

        // single M0 word read, ready in first BUSY cycle
        set_req(0, 1'b0, MEM_MODE_WORD, 32'h8000_0000, 32'h0);
        tick();
        @(negedge clk);
        chk("t1_mem_req", bus.mem_req, 64'd1);
        chk("t1_mem_addr", bus.mem_addr, 64'h8000_0000);
        chk("t1_mem_mode", bus.mem_mode, 64'h7);
        bus.mem_ready = 1'b1; bus.mem_dat_i = 32'h1234_5678;
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("t1_ack", bus.m_ack, 64'b01);
        chk("t1_rdata0", bus.m_rdata[0], 64'h1234_5678);
        tick();

        // stray mem_ready while idle
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("t6_ack", bus.m_ack, 64'd0);
        chk("t6_mem_req", bus.mem_req, 64'd0);

        // M1 write held in BUSY for 5 cycles
        set_req(1, 1'b1, 3'b010, 32'h1000, 32'hCAFE_F00D);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_wen", bus.mem_wen, 64'd1);
            chk("t3_addr", bus.mem_addr, 64'h1000);
            chk("t3_dat_o", bus.mem_dat_o, 64'hCAFE_F00D);
            chk("t3_mode", bus.mem_mode, 64'h2);
            tick();
        end
        bus.mem_ready = 1'b1; bus.mem_dat_i = 32'h5555_AAAA;
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("t3_ack", bus.m_ack, 64'b10);
        chk("t3_wen_after", bus.mem_wen, 64'd0);
        chk("t3_rdata1", bus.m_rdata[1], 64'h5555_AAAA);
        chk("t3_rdata0_kept", bus.m_rdata[0], 64'h1234_5678);
        tick();

        // reset in the middle of BUSY
        set_req(0, 1'b0, MEM_MODE_WORD, 32'h44, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("t4_mem_req", bus.mem_req, 64'd0);
        chk("t4_ack", bus.m_ack, 64'd0);
        chk("t4_rdata", bus.m_rdata, 64'd0);
        chk("t4_addr", bus.mem_addr, 64'd0);

        // both masters held after reset: M0 first, then alternate
        set_req(1, 1'b0, MEM_MODE_WORD, 32'h2000, 32'h0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk("t2_grant", bus.grant_id, 64'(k % 2));
            chk("t2_addr", bus.mem_addr, (k % 2) ? 64'h2000 : 64'h44);
            bus.mem_ready = 1'b1; bus.mem_dat_i = 32'hA0 + 32'(k);
            tick();
            bus.mem_ready = 1'b0;
            @(negedge clk);
            chk("t2_ack", bus.m_ack, (k % 2) ? 64'b10 : 64'b01);
            tick();
            bus.m_req = 2'b11;
        end
        bus.m_req = 2'b00;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // no mem_ready: abort after TMO+1 BUSY cycles
        set_req(0, 1'b0, MEM_MODE_WORD, 32'h300, 32'h0);
        tick();
        repeat (8) tick();
        @(negedge clk);
        chk("t5_no_early_ack", bus.m_ack, 64'd0);
        tick();
        @(negedge clk);
        chk("t5_ack", bus.m_ack, 64'b01);
        chk("t5_err", bus.m_err, 64'b01);
        chk("t5_rdata", bus.m_rdata[0], 64'hDEAD_BEEF);
        tick();
        // mem_ready on the timeout edge wins
        set_req(0, 1'b0, MEM_MODE_WORD, 32'h304, 32'h0);
        tick();
        repeat (8) tick();
        bus.mem_ready = 1'b1; bus.mem_dat_i = 32'h0BAD_CAFE;
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("t5_race_ack", bus.m_ack, 64'b01);
        chk("t5_race_err", bus.m_err, 64'd0);
        chk("t5_race_rdata", bus.m_rdata[0], 64'h0BAD_CAFE);
        tick();
`endif

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
